// File: rtl/ch_mux_regfile.sv
// Control register file for the channel mux: shadow/active enable and select
// registers with frame-synchronised commit, auto-commit mode and masked sticky events.
module ch_mux_regfile #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_CH     = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [7:0]            BLOCK_ID   = 8'hC4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_wr,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_sync,
  input  logic [NUM_CH-1:0]     i_ch_event,
  output logic [NUM_CH-1:0]     o_ch_ena,
  output logic [NUM_CH-1:0]     o_ch_sel,
  output logic                  o_commit_pending,
  output logic                  o_irq
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] OFF_ENA    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_SEL    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_EVENT  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] OFF_ID     = ADDR_WIDTH'(6);

  logic [NUM_CH-1:0]     ena_sh_q, ena_sh_d, sel_sh_q, sel_sh_d;
  logic [NUM_CH-1:0]     ena_q, ena_d, sel_q, sel_d;
  logic [NUM_CH-1:0]     event_q, event_d, mask_q, mask_d;
  logic                  auto_q, auto_d, irq_q, irq_d;
  logic [0:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDR_WIDTH-1:0] off;
  logic [NUM_CH-1:0]     wdata, clr;
  logic                  wr_ena, wr_sel, wr_ctrl, wr_event, wr_mask;

  function automatic logic [DATA_WIDTH-1:0] zext(input logic [NUM_CH-1:0] v);
    return DATA_WIDTH'(v);
  endfunction

  always_comb begin
    // Relative offset wraps modulo 2^ADDR_WIDTH, so each address maps to one offset.
    off      = i_addr - BASE_ADDR;
    wdata    = i_data[NUM_CH-1:0];
    wr_ena   = i_wr && (off == OFF_ENA);
    wr_sel   = i_wr && (off == OFF_SEL);
    wr_ctrl  = i_wr && (off == OFF_CTRL);
    wr_event = i_wr && (off == OFF_EVENT);
    wr_mask  = i_wr && (off == OFF_MASK);

    ena_sh_d = wr_ena  ? wdata     : ena_sh_q;
    sel_sh_d = wr_sel  ? wdata     : sel_sh_q;
    mask_d   = wr_mask ? wdata     : mask_q;
    auto_d   = wr_ctrl ? i_data[1] : auto_q;

    state_d = state_q;
    ena_d   = ena_q;
    sel_d   = sel_q;
    // Entering or staying in auto mode cancels any armed commit.
    if (auto_d) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (wr_ctrl && i_data[0]) state_d = ST_ARMED;
        ST_ARMED: begin
          if (i_sync) begin
            state_d = ST_IDLE;
            ena_d   = ena_sh_q;
            sel_d   = sel_sh_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (auto_q) begin
      ena_d = ena_sh_q;
      sel_d = sel_sh_q;
    end

    // A new event pulse wins over a same-cycle W1C clear.
    clr     = wr_event ? wdata : '0;
    event_d = (event_q & ~clr) | i_ch_event;
    irq_d   = |(event_q & mask_q);

    rdata_d = rdata_q;
    if (!i_wr) begin
      case (off)
        OFF_ENA:    rdata_d = zext(ena_sh_q);
        OFF_SEL:    rdata_d = zext(sel_sh_q);
        OFF_CTRL:   rdata_d = DATA_WIDTH'({auto_q, 1'b0});
        OFF_STATUS: rdata_d = DATA_WIDTH'({auto_q, state_q == ST_ARMED});
        OFF_EVENT:  rdata_d = zext(event_q);
        OFF_MASK:   rdata_d = zext(mask_q);
        OFF_ID:     rdata_d = DATA_WIDTH'(BLOCK_ID);
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ena_sh_q <= '0;
      sel_sh_q <= '0;
      ena_q    <= '0;
      sel_q    <= '0;
      event_q  <= '0;
      mask_q   <= '0;
      auto_q   <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= ST_IDLE;
      rdata_q  <= '0;
    end else begin
      ena_sh_q <= ena_sh_d;
      sel_sh_q <= sel_sh_d;
      ena_q    <= ena_d;
      sel_q    <= sel_d;
      event_q  <= event_d;
      mask_q   <= mask_d;
      auto_q   <= auto_d;
      irq_q    <= irq_d;
      state_q  <= state_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_data           = rdata_q;
  assign o_ch_ena         = ena_q;
  assign o_ch_sel         = sel_q;
  assign o_commit_pending = (state_q == ST_ARMED);
  assign o_irq            = irq_q;

endmodule

// File: tb/tb_ch_mux_regfile.sv
// Directed bench for ch_mux_regfile at a relocated base address; read data is
// checked through an expected-value queue, other outputs by immediate assertions.
module tb_ch_mux_regfile;

  localparam logic [7:0] A_ENA    = 8'h40;
  localparam logic [7:0] A_SEL    = 8'h41;
  localparam logic [7:0] A_CTRL   = 8'h42;
  localparam logic [7:0] A_STATUS = 8'h43;
  localparam logic [7:0] A_EVENT  = 8'h44;
  localparam logic [7:0] A_MASK   = 8'h45;
  localparam logic [7:0] A_ID     = 8'h46;

  logic       i_clk, i_rst, i_wr, i_sync;
  logic [7:0] i_addr, i_data, o_data;
  logic [3:0] i_ch_event, o_ch_ena, o_ch_sel;
  logic       o_commit_pending, o_irq;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  ch_mux_regfile #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_CH(4), .BASE_ADDR(8'h40), .BLOCK_ID(8'hC4)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_data(i_data), .i_wr(i_wr),
    .o_data(o_data), .i_sync(i_sync), .i_ch_event(i_ch_event), .o_ch_ena(o_ch_ena),
    .o_ch_sel(o_ch_sel), .o_commit_pending(o_commit_pending), .o_irq(o_irq)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    i_addr = a;
    i_data = d;
    i_wr   = 1'b1;
    tick();
    i_wr   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e);
    i_addr = a;
    i_wr   = 1'b0;
    exp_q.push_back(e);
    tick();
    check($sformatf("rd_%0h", a), o_data, exp_q.pop_front());
  endtask

  task automatic sync_pulse();
    i_sync = 1'b1;
    tick();
    i_sync = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    i_rst = 1'b1; i_wr = 1'b0; i_sync = 1'b0;
    i_addr = 8'h00; i_data = 8'h00; i_ch_event = 4'h0;
    repeat (3) tick();
    i_rst = 1'b0;

    check("rst_ena", 8'(o_ch_ena), 8'h0);
    check("rst_sel", 8'(o_ch_sel), 8'h0);
    check("rst_irq", 8'(o_irq), 8'h0);
    check("rst_pend", 8'(o_commit_pending), 8'h0);
    rd(A_ENA, 8'h00); rd(A_SEL, 8'h00); rd(A_CTRL, 8'h00); rd(A_STATUS, 8'h00);
    rd(A_EVENT, 8'h00); rd(A_MASK, 8'h00); rd(A_ID, 8'hC4);
    rd(8'h47, 8'h00);
    rd(8'h00, 8'h00);
    wr(A_ID, 8'hFF);
    rd(A_ID, 8'hC4);

    // Armed commit; shadow rewritten while armed
    wr(A_ENA, 8'h0A);
    wr(A_SEL, 8'h05);
    wr(A_CTRL, 8'h01);
    check("arm_pend", 8'(o_commit_pending), 8'h1);
    check("arm_ena", 8'(o_ch_ena), 8'h0);
    rd(A_STATUS, 8'h01);
    wr(A_ENA, 8'h03);
    check("pre_sync_ena", 8'(o_ch_ena), 8'h0);
    sync_pulse();
    check("commit_ena", 8'(o_ch_ena), 8'h3);
    check("commit_sel", 8'(o_ch_sel), 8'h5);
    check("commit_pend", 8'(o_commit_pending), 8'h0);

    // Arming write coincident with sync does not commit
    wr(A_ENA, 8'h09);
    i_sync = 1'b1;
    wr(A_CTRL, 8'h01);
    i_sync = 1'b0;
    check("coinc_pend", 8'(o_commit_pending), 8'h1);
    check("coinc_ena", 8'(o_ch_ena), 8'h3);
    repeat (9) tick();
    check("wait_ena", 8'(o_ch_ena), 8'h3);
    sync_pulse();
    check("second_sync_ena", 8'(o_ch_ena), 8'h9);
    check("second_sync_pend", 8'(o_commit_pending), 8'h0);

    // Sync while idle is ignored
    wr(A_ENA, 8'h0C);
    sync_pulse();
    check("idle_sync_ena", 8'(o_ch_ena), 8'h9);

    // Auto mode
    wr(A_CTRL, 8'h02);
    wr(A_ENA, 8'h06);
    check("auto_prev_ena", 8'(o_ch_ena), 8'hC);
    tick();
    check("auto_ena", 8'(o_ch_ena), 8'h6);
    rd(A_STATUS, 8'h02);
    rd(A_CTRL, 8'h02);

    // Auto off freezes, auto on cancels armed
    wr(A_CTRL, 8'h00);
    wr(A_ENA, 8'h01);
    tick();
    check("frozen_ena", 8'(o_ch_ena), 8'h6);
    wr(A_CTRL, 8'h01);
    check("rearm_pend", 8'(o_commit_pending), 8'h1);
    wr(A_CTRL, 8'h02);
    check("cancel_pend", 8'(o_commit_pending), 8'h0);
    tick();
    check("cancel_ena", 8'(o_ch_ena), 8'h1);
    wr(A_CTRL, 8'h00);

    // Events, mask and irq
    wr(A_MASK, 8'h02);
    check("irq_idle", 8'(o_irq), 8'h0);
    i_ch_event = 4'b0010;
    tick();
    i_ch_event = 4'b0000;
    tick();
    check("irq_set", 8'(o_irq), 8'h1);
    rd(A_EVENT, 8'h02);
    i_ch_event = 4'b0010;
    wr(A_EVENT, 8'h02);
    i_ch_event = 4'b0000;
    rd(A_EVENT, 8'h02);
    check("irq_set_wins", 8'(o_irq), 8'h1);
    wr(A_EVENT, 8'h02);
    rd(A_EVENT, 8'h00);
    check("irq_clr", 8'(o_irq), 8'h0);
    i_ch_event = 4'b0101;
    tick();
    i_ch_event = 4'b0000;
    tick();
    check("irq_masked", 8'(o_irq), 8'h0);
    rd(A_EVENT, 8'h05);

    // Random shadow select writes read back
    for (int i = 0; i < 6; i++) begin
      v = 8'($urandom_range(0, 15));
      wr(A_SEL, v);
      rd(A_SEL, v);
    end

    // Reset while armed with all events set
    i_ch_event = 4'hF;
    tick();
    i_ch_event = 4'h0;
    wr(A_ENA, 8'h0F);
    wr(A_CTRL, 8'h01);
    check("pre_rst_pend", 8'(o_commit_pending), 8'h1);
    i_rst = 1'b1;
    i_sync = 1'b1;
    tick();
    i_rst = 1'b0;
    i_sync = 1'b0;
    check("post_rst_ena", 8'(o_ch_ena), 8'h0);
    check("post_rst_sel", 8'(o_ch_sel), 8'h0);
    check("post_rst_irq", 8'(o_irq), 8'h0);
    check("post_rst_pend", 8'(o_commit_pending), 8'h0);
    rd(A_EVENT, 8'h00);
    rd(A_ENA, 8'h00);
    rd(A_MASK, 8'h00);
    sync_pulse();
    check("post_rst_sync_ena", 8'(o_ch_ena), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ch_mux_regfile.md
Name: ch_mux_regfile

Overview:
- Parametrised memory-mapped control register file for the channel multiplexer. Generalises the fixed 4-channel enable/select pair to NUM_CH channels at a relocatable base address.
- Adds shadow/active double buffering with commit synchronised to a frame strobe, an auto-commit mode, sticky W1C per-channel event capture with mask, and an interrupt output.
- Sits between the host bus decoder and the channel mux datapath.

Parameters:
- ADDR_WIDTH, 8, bus address width.
- DATA_WIDTH, 8, bus data width; must be >= NUM_CH.
- NUM_CH, 4, number of mux channels (1..DATA_WIDTH).
- BASE_ADDR, 8'h00, address of register offset 0; offsets 0..6 used.
- BLOCK_ID, 8'hC4, constant returned at offset 6, truncated/zero-extended to DATA_WIDTH.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_addr  in  ADDR_WIDTH  register address.
- i_data  in  DATA_WIDTH  write data.
- i_wr  in  1  write strobe; 0 = read cycle.
- o_data  out  DATA_WIDTH  registered read data.
- i_sync  in  1  single-cycle frame boundary strobe; commit point.
- i_ch_event  in  NUM_CH  per-channel event pulses, level-sampled each cycle.
- o_ch_ena  out  NUM_CH  active channel enables.
- o_ch_sel  out  NUM_CH  active channel selects.
- o_commit_pending  out  1  commit armed, waiting for i_sync.
- o_irq  out  1  |(EVENT & EVENT_MASK), registered.

Behaviour:
- Register map (offset from BASE_ADDR), register width NUM_CH unless noted:
  - 0 ENA_SH: RW shadow enables.
  - 1 SEL_SH: RW shadow selects.
  - 2 CTRL: bit0 COMMIT (write 1 arms; reads 0); bit1 AUTO (RW).
  - 3 STATUS: RO; bit0 = pending; bit1 = AUTO; other bits 0.
  - 4 EVENT: RW1C sticky.
  - 5 EVENT_MASK: RW.
  - 6 ID: RO BLOCK_ID.
- Writes use i_data[NUM_CH-1:0]; reads are zero-extended to DATA_WIDTH.
- Writes to RO or unmapped addresses are ignored.
- Reads of unmapped addresses return 0.
- Read path:
  - When i_wr=0, o_data is loaded with the addressed register on the rising edge; 1-cycle latency.
  - When i_wr=1, o_data holds its value.
  - Reads have no side effects.
- Reset: all registers, o_data, o_ch_ena, o_ch_sel, o_commit_pending and o_irq go to 0; FSM goes to IDLE. Reset overrides all concurrent events.
- Commit FSM (applies when AUTO=0):
  - IDLE: a write of CTRL with bit0=1 moves to ARMED; o_commit_pending=1 from the next cycle.
  - ARMED: on i_sync=1, active <= shadow (values present in the same cycle), go to IDLE, pending clears. The new o_ch_ena/o_ch_sel are visible the cycle after i_sync.
  - i_sync in the same cycle as the arming write does not commit; commit happens on the first i_sync strictly after the arming cycle.
  - Shadow writes while ARMED are allowed; the latest shadow value is committed.
  - Re-arming while ARMED has no effect.
  - i_sync while IDLE has no effect.
- Auto mode (AUTO=1):
  - Active registers track shadow with 1-cycle latency; i_sync is ignored.
  - The FSM is forced to IDLE and pending clears.
  - A write that sets AUTO while ARMED cancels the ARMED state; the active registers then take shadow the next cycle.
  - Writing AUTO=0 freezes active at its current value.
- EVENT register:
  - Each cycle, bit n is set when i_ch_event[n]=1.
  - A write to EVENT clears bits where i_data=1.
  - Set and clear of the same bit in the same cycle: set wins (bit stays 1).
- o_irq = registered |(EVENT & EVENT_MASK); it updates 1 cycle after EVENT or MASK changes.

Test Plan:
- Reset then read offsets 0..6 -> 0,0,0,0,0,0,BLOCK_ID, each one cycle after address; o_ch_ena=o_ch_sel=0, o_irq=0.
- Write ENA_SH=4'hA, SEL_SH=4'h5, CTRL=1 -> o_ch_ena stays 0 and o_commit_pending=1. Then write ENA_SH=4'h3 and pulse i_sync -> next cycle o_ch_ena=4'h3, o_ch_sel=4'h5, pending=0.
- Arming write of CTRL=1 coincident with i_sync -> no commit that cycle; second i_sync 10 cycles later commits.
- Write CTRL=2 (AUTO), then ENA_SH=4'h6 -> o_ch_ena=4'h6 one cycle after the write with no i_sync; STATUS reads 2'b10.
- Pulse i_ch_event=4'b0010 with EVENT_MASK=4'b0010 -> EVENT=2, o_irq=1. Write EVENT=2 in the same cycle as a new event[1] pulse -> bit stays 1. Write EVENT=2 alone -> o_irq=0 next cycle.
- Assert i_rst while ARMED with EVENT=4'hF -> all outputs 0, pending 0. A subsequent i_sync does not change o_ch_ena.
